// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream FIFO family.
package stream_pkg;

   typedef enum logic {WR_ACCEPT, WR_DROP} stream_wr_state_t;

   localparam int PTR_MAX = 32;

   // Pointers carry one extra wrap bit above the address bits (aw).
   // Full means only that wrap bit differs.
   function automatic logic ptr_full(input logic [PTR_MAX-1:0] wr,
                                     input logic [PTR_MAX-1:0] rd,
                                     input int unsigned aw);
      return (wr ^ rd) == (PTR_MAX'(1) << aw);
   endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
module stream_fifo_ram #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/stream_pkt_fifo.sv
// Store-and-forward packet FIFO; oversize packets are dropped whole.
// Define STREAM_PKT_FIFO_ERR_DROP_EN to also drop packets flagged by s_err on the last beat.
module stream_pkt_fifo
   import stream_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 16,
   parameter int MAX_PKT_BEATS = 4,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    s_data,
   input  logic                     s_last,
   input  logic                     s_err,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [DATA_WIDTH-1:0]    m_data,
   output logic                     m_last,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   pkt_count,
   output logic [CNT_WIDTH-1:0]     drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned BW = $clog2(MAX_PKT_BEATS) + 1;
   localparam logic [BW-1:0] LAST_IDX = BW'(MAX_PKT_BEATS - 1);

   stream_wr_state_t state, state_nxt;
   logic [PW-1:0]    wr_ptr, wr_tmp, rd_ptr, rd_addr;
   logic [BW-1:0]    beat_cnt;
   logic             full, s_fire, wr_en, err_drop, commit, drop_ev, oversize;
   logic             m_fire, ram_re, ram_vld, adv;
   logic [DATA_WIDTH:0] ram_q;

`ifdef STREAM_PKT_FIFO_ERR_DROP_EN
   assign err_drop = s_err;
`else
   logic unused_err;
   assign unused_err = s_err;
   assign err_drop   = 1'b0;
`endif

   // rd_ptr tracks popped beats, so entries still in the read pipeline stay protected.
   assign full     = ptr_full(PTR_MAX'(wr_tmp), PTR_MAX'(rd_ptr), AW);
   assign s_fire   = s_valid && s_ready;
   assign wr_en    = s_fire && (state == WR_ACCEPT);
   assign oversize = !s_last && (beat_cnt == LAST_IDX);
   assign commit   = wr_en && s_last && !err_drop;
   assign drop_ev  = wr_en && ((s_last && err_drop) || oversize);

   always_ff @(posedge clk) begin
      if (rst) state <= WR_ACCEPT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      if (!rst) begin
         case (state)
            WR_ACCEPT: begin
               s_ready = !full;
               if (s_valid && !full && oversize) state_nxt = WR_DROP;
            end
            WR_DROP: begin
               s_ready = 1'b1;
               if (s_valid && s_last) state_nxt = WR_ACCEPT;
            end
            default: state_nxt = WR_ACCEPT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         wr_tmp   <= '0;
         beat_cnt <= '0;
      end else if (wr_en) begin
         if (s_last) begin
            beat_cnt <= '0;
            if (err_drop) wr_tmp <= wr_ptr;
            else begin
               wr_tmp <= wr_tmp + PW'(1);
               wr_ptr <= wr_tmp + PW'(1);
            end
         end else if (oversize) begin
            wr_tmp   <= wr_ptr;
            beat_cnt <= '0;
         end else begin
            wr_tmp   <= wr_tmp + PW'(1);
            beat_cnt <= beat_cnt + BW'(1);
         end
      end
   end

   stream_fifo_ram #(.WIDTH(DATA_WIDTH + 1), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_tmp[AW-1:0]),
      .wdata ({s_last, s_data}),
      .re    (ram_re),
      .raddr (rd_addr[AW-1:0]),
      .rdata (ram_q)
   );

   // Two-stage read: RAM output stage, then the output register.
   assign m_fire = m_valid && m_ready;
   assign adv    = ram_vld && (!m_valid || m_fire);
   assign ram_re = (rd_addr != wr_ptr) && (!ram_vld || adv);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr <= '0;
         rd_ptr  <= '0;
         ram_vld <= 1'b0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
      end else begin
         if (ram_re) rd_addr <= rd_addr + PW'(1);
         ram_vld <= ram_re || (ram_vld && !adv);
         if (adv) begin
            m_valid          <= 1'b1;
            {m_last, m_data} <= ram_q;
         end else if (m_fire) begin
            m_valid <= 1'b0;
         end
         if (m_fire) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_count  <= '0;
         drop_count <= '0;
      end else begin
         case ({commit, m_fire && m_last})
            2'b10:   pkt_count <= pkt_count + 1'b1;
            2'b01:   pkt_count <= pkt_count - 1'b1;
            default: pkt_count <= pkt_count;
         endcase
         if (drop_ev && (drop_count != '1)) drop_count <= drop_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_pkt_fifo.sv
// Directed and randomized bench for stream_pkt_fifo (default parameters).
module tb_stream_pkt_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0, s_err = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
   logic        s_ready, m_last, m_valid;
   logic [31:0] m_data;
   logic [4:0]  pkt_count;
   logic [15:0] drop_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_pkt_fifo dut (
      .clk        (clk),
      .rst        (rst),
      .s_data     (s_data),
      .s_last     (s_last),
      .s_err      (s_err),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .pkt_count  (pkt_count),
      .drop_count (drop_count)
   );

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_err = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic l, input logic e);
      int cnt = 0;
      s_data = d; s_last = l; s_err = e; s_valid = 1'b1;
      while (!s_ready && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (!s_ready) begin
         checks++; errors++;
         $display("FAIL push_timeout data %h s_ready stuck at 0, required 1", d);
      end else begin
         @(posedge clk);
      end
      @(negedge clk);
      s_valid = 1'b0; s_err = 1'b0;
   endtask

   task automatic pop(output logic [31:0] d, output logic l);
      int cnt = 0;
      m_ready = 1'b1;
      while (!m_valid && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      d = m_data; l = m_last;
      if (!m_valid) begin
         checks++; errors++;
         $display("FAIL pop_timeout m_valid stuck at 0, required 1");
         d = 'x;
      end else begin
         @(posedge clk);
      end
      @(negedge clk);
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({s_ready, m_valid, m_last} !== 3'b000 || m_data !== 32'h0 ||
          pkt_count !== 5'd0 || drop_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_state rdy/vld/last %b%b%b data %h pkt %0d drop %0d, required all 0",
                  s_ready, m_valid, m_last, m_data, pkt_count, drop_count);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release s_ready %b, required 1", s_ready);
      end
   endtask

   task automatic test_basic();
      logic [31:0] exp [3];
      logic [31:0] d;
      logic        l;
      exp = '{32'h11, 32'h22, 32'h33};
      apply_reset();
      push(32'h11, 0, 0);
      push(32'h22, 0, 0);
      push(32'h33, 1, 0);
      checks++;
      if (m_valid !== 1'b0 || pkt_count !== 5'd1) begin
         errors++;
         $display("FAIL basic_edge1 m_valid %b pkt %0d, required 0 and 1", m_valid, pkt_count);
      end
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_edge2 m_valid %b, required 0", m_valid);
      end
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'h11) begin
         errors++;
         $display("FAIL basic_lat m_valid %b data %h, required 1 and 11", m_valid, m_data);
      end
      for (int i = 0; i < 3; i++) begin
         pop(d, l);
         checks++;
         if (d !== exp[i] || l !== (i == 2)) begin
            errors++;
            $display("FAIL basic_beat%0d got %h last %b, required %h last %b", i, d, l, exp[i], i == 2);
         end
      end
      checks++;
      if (pkt_count !== 5'd0) begin
         errors++;
         $display("FAIL basic_pkt_count got %0d, required 0", pkt_count);
      end
   endtask

   task automatic test_oversize();
      logic [31:0] d;
      logic        l;
      apply_reset();
      for (int i = 0; i < 5; i++) push(32'h1 + i, i == 4, 0);
      push(32'hA0, 0, 0);
      push(32'hA1, 1, 0);
      pop(d, l);
      checks++;
      if (d !== 32'hA0 || l !== 1'b0) begin
         errors++;
         $display("FAIL oversize_beat0 got %h last %b, required a0 last 0", d, l);
      end
      pop(d, l);
      checks++;
      if (d !== 32'hA1 || l !== 1'b1) begin
         errors++;
         $display("FAIL oversize_beat1 got %h last %b, required a1 last 1", d, l);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (drop_count !== 16'd1 || m_valid !== 1'b0 || pkt_count !== 5'd0) begin
         errors++;
         $display("FAIL oversize_after drop %0d m_valid %b pkt %0d, required 1 0 0",
                  drop_count, m_valid, pkt_count);
      end
   endtask

   task automatic test_fill();
      logic [31:0] d;
      logic        l;
      apply_reset();
      for (int i = 0; i < 16; i++) push(32'h40 + i, (i % 4) == 3, 0);
      checks++;
      if (s_ready !== 1'b0 || pkt_count !== 5'd4 || m_valid !== 1'b1) begin
         errors++;
         $display("FAIL fill_full s_ready %b pkt %0d m_valid %b, required 0 4 1",
                  s_ready, pkt_count, m_valid);
      end
      for (int i = 0; i < 16; i++) begin
         pop(d, l);
         checks++;
         if (d !== 32'h40 + i || l !== ((i % 4) == 3)) begin
            errors++;
            $display("FAIL fill_beat%0d got %h last %b, required %h last %b",
                     i, d, l, 32'h40 + i, (i % 4) == 3);
         end
         if (i == 0) begin
            checks++;
            if (s_ready !== 1'b1) begin
               errors++;
               $display("FAIL fill_ready_back s_ready %b, required 1", s_ready);
            end
         end
      end
      checks++;
      if (pkt_count !== 5'd0) begin
         errors++;
         $display("FAIL fill_pkt_count got %0d, required 0", pkt_count);
      end
   endtask

   task automatic test_err();
      logic [31:0] d;
      logic        l;
      apply_reset();
      push(32'h51, 0, 0);
      push(32'h52, 0, 0);
      push(32'h53, 1, 1);
      repeat (4) @(negedge clk);
`ifdef STREAM_PKT_FIFO_ERR_DROP_EN
      checks++;
      if (m_valid !== 1'b0 || drop_count !== 16'd1 || pkt_count !== 5'd0) begin
         errors++;
         $display("FAIL err_drop m_valid %b drop %0d pkt %0d, required 0 1 0",
                  m_valid, drop_count, pkt_count);
      end
`else
      checks++;
      if (m_valid !== 1'b1 || drop_count !== 16'd0 || pkt_count !== 5'd1) begin
         errors++;
         $display("FAIL err_keep m_valid %b drop %0d pkt %0d, required 1 0 1",
                  m_valid, drop_count, pkt_count);
      end
      for (int i = 0; i < 3; i++) begin
         pop(d, l);
         checks++;
         if (d !== 32'h51 + i || l !== (i == 2)) begin
            errors++;
            $display("FAIL err_beat%0d got %h last %b, required %h last %b", i, d, l, 32'h51 + i, i == 2);
         end
      end
`endif
   endtask

   task automatic test_mid_reset();
      logic [31:0] d;
      logic        l;
      apply_reset();
      push(32'h61, 0, 0);
      push(32'h62, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (pkt_count !== 5'd0 || drop_count !== 16'd0 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_state pkt %0d drop %0d s_ready %b m_valid %b, required 0 0 0 0",
                  pkt_count, drop_count, s_ready, m_valid);
      end
      rst = 1'b0;
      #1;
      push(32'hAA, 1, 0);
      pop(d, l);
      checks++;
      if (d !== 32'hAA || l !== 1'b1) begin
         errors++;
         $display("FAIL midrst_beat got %h last %b, required aa last 1", d, l);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || pkt_count !== 5'd0) begin
         errors++;
         $display("FAIL midrst_extra m_valid %b pkt %0d, required 0 0", m_valid, pkt_count);
      end
   endtask

   task automatic test_random();
      int lens [1000];
      int total = 0;
      logic [32:0] exp_q [$];
      apply_reset();
      for (int p = 0; p < 1000; p++) begin
         lens[p] = int'($urandom_range(1, 4));
         total += lens[p];
      end
      fork
         begin
            int n = 0;
            for (int p = 0; p < 1000; p++) begin
               for (int b = 0; b < lens[p]; b++) begin
                  repeat ($urandom_range(0, 2)) @(negedge clk);
                  exp_q.push_back({b == lens[p] - 1, 32'(n)});
                  push(32'(n), b == lens[p] - 1, 0);
                  n++;
               end
            end
         end
         begin
            int rcv = 0;
            int cyc = 0;
            logic [32:0] e;
            while (rcv < total && cyc < 60000) begin
               @(negedge clk);
               cyc++;
               checks++;
               if (int'(pkt_count) > 16) begin
                  errors++;
                  $display("FAIL rand_pkt_count got %0d, required <= 16", pkt_count);
               end
               m_ready = 1'($urandom_range(0, 1));
               if (m_valid && m_ready) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL rand_extra got %h last %b, required no beat", m_data, m_last);
                  end else begin
                     e = exp_q.pop_front();
                     if ({m_last, m_data} !== e) begin
                        errors++;
                        $display("FAIL rand_beat%0d got %h last %b, required %h last %b",
                                 rcv, m_data, m_last, e[31:0], e[32]);
                     end
                  end
                  rcv++;
               end
            end
            checks++;
            if (rcv != total) begin
               errors++;
               $display("FAIL rand_count got %0d beats, required %0d", rcv, total);
            end
         end
      join
      @(negedge clk);
      m_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_oversize();
      test_fill();
      test_err();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_pkt_fifo.md
# stream_pkt_fifo

Store-and-forward packet FIFO for AXI-Stream-style paths: a packet becomes visible on the master side only after its last beat has been written. Oversized packets and, optionally, error-flagged packets are discarded whole. It is the parametrised successor to stream_fifo and sits at the same points: ingress buffering ahead of parsers, and egress ahead of MACs that cannot tolerate mid-packet bubbles.

## Interface
- DATA_WIDTH, 32: payload width. Callers pack user/keep/data into it.
- DEPTH, 16: entries. Must be a power of two and ≥ MAX_PKT_BEATS.
- MAX_PKT_BEATS, 4: largest legal packet in beats.
- CNT_WIDTH, 16: width of drop_count.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_WIDTH  write data.
- s_last  in  1  last beat of packet.
- s_err  in  1  packet error flag, sampled with s_last.
- s_valid  in  1  write valid.
- s_ready  out  1  write ready.
- m_data  out  DATA_WIDTH  read data.
- m_last  out  1  last beat.
- m_valid  out  1  read valid.
- m_ready  in  1  read ready.
- pkt_count  out  $clog2(DEPTH)+1  committed packets not yet fully read.
- drop_count  out  CNT_WIDTH  discarded packets; saturates at all-ones.

## Operation
- Storage: DEPTH × (DATA_WIDTH+1) words, with the last flag stored alongside the data.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally:
  - wr_ptr: committed write pointer.
  - wr_tmp: speculative write pointer.
  - rd_ptr: read pointer.
- Full when wr_tmp and rd_ptr differ only in the MSB.
- Write FSM states are WR_ACCEPT and WR_DROP. Reset state is WR_ACCEPT.
- In WR_ACCEPT:
  - s_ready = !full.
  - Each accepted beat writes at wr_tmp, increments wr_tmp and increments beat_cnt.
  - Accepted beat with s_last and no error: wr_ptr ← wr_tmp+1, beat_cnt ← 0, pkt_count +1.
  - Accepted beat with beat_cnt == MAX_PKT_BEATS-1 and !s_last (oversize): wr_tmp ← wr_ptr, beat_cnt ← 0, drop_count +1, go to WR_DROP.
  - A packet of exactly MAX_PKT_BEATS beats is legal.
- In WR_DROP:
  - s_ready = 1. Beats are consumed and not written.
  - Accepted s_last returns the FSM to WR_ACCEPT.
- Read side:
  - The RAM read feeds a one-entry output register.
  - The register loads when rd_ptr != wr_ptr and the register is empty or being popped.
  - A pop of an m_last beat decrements pkt_count.
  - A commit and a last-beat pop in the same cycle leave pkt_count unchanged.
- Full-rate on both sides. Simultaneous read and write are always legal.
- DEPTH ≥ MAX_PKT_BEATS guarantees no deadlock: a full FIFO always holds at least one committed packet.

## Timing
- Reset (rst high at an edge), including mid-packet:
  - s_ready=0, m_valid=0, m_data=0, m_last=0, pkt_count=0, drop_count=0.
  - Pointers and beat_cnt are cleared and the FSM returns to WR_ACCEPT.
  - Any partial packet is lost.
  - s_ready rises in the first cycle after rst deasserts.
- Latency: s_last accepted at edge N with the FIFO empty → m_valid high after edge N+2. The first beat of that packet is on m_data.
- Once m_valid is asserted, m_data and m_last stay stable until m_ready.
- pkt_count and drop_count are registered and update at the edge following the triggering event.
- drop_count holds at 2^CNT_WIDTH-1.

## Configuration
- Macro: STREAM_PKT_FIFO_ERR_DROP_EN.
- Defined: s_err=1 on an accepted s_last beat discards the packet: wr_tmp ← wr_ptr, no commit, drop_count +1.
- Undefined: s_err is ignored and error-flagged packets are committed normally. Only oversize drops occur.
- The port list is identical in both builds.

## Structure
- stream_pkg holds:
  - typedef enum logic {WR_ACCEPT, WR_DROP} stream_wr_state_t.
  - function ptr_full(wr, rd), shared with stream_fifo.
- Sub-module stream_fifo_ram: simple dual-port RAM with one synchronous write port and one synchronous read port, parametrised by WIDTH and DEPTH. It is instantiated once.
- The FSM, pointers and output register live in the top module.

## Test plan
- Reset, then a 3-beat packet with data 0x11/0x22/0x33 → m_valid rises 2 cycles after the last handshake; beats are read in order; m_last on 0x33; pkt_count 1→0.
- 5-beat packet with MAX_PKT_BEATS=4, followed by a 2-beat packet → the first packet is discarded entirely; drop_count=1; only the 2-beat packet appears at the output.
- Fill to 16 entries with four 4-beat packets while m_ready=0 → s_ready=0 and pkt_count=4. Raise m_ready → all 16 beats are read in order and s_ready reasserts the cycle after the first pop.
- 3-beat packet with s_err=1 on its last beat:
  - STREAM_PKT_FIFO_ERR_DROP_EN defined → nothing output, drop_count=1.
  - Undefined → all 3 beats are output and drop_count=0.
- Assert rst after 2 beats of a packet, then send a complete 1-beat packet 0xAA → only 0xAA is output; pkt_count and drop_count read 0 right after reset.
- Continuous random m_ready and s_valid for 1000 packets of 1–4 beats → output matches input order; no beat is lost; pkt_count never exceeds DEPTH.
